// File: rtl/mode_seq_pkg.sv
// Shared types for the mode sequencer: FSM state encoding and mode-width helper.
package mode_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD_ADV,
    ST_HELD_BACK,
    ST_LOCKED
  } seq_state_e;

  // Width of the mode bus: max(1, clog2(n)).
  function automatic int mode_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Debounces one raw button: a 2-FF synchroniser feeds a stability counter.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive
// synchronised samples differ from it; rise/fall are one-cycle strobes.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic             w_differs;

  assign w_differs = r_sync[1] ^ r_level;

  // Bring the asynchronous button into the clk domain.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[0], i_btn};
  end

  // Count consecutive differing samples; flip the level and strobe on the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
        r_rise  <= ~r_level;
        r_fall  <= r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/mode_sequencer.sv
// Mode sequencer: short advance/back presses step through NUM_MODES modes
// with wrap-around, a long press on either button returns to home (mode 0).
// Optional idle timeout back to home is enabled by defining MODE_SEQ_TIMEOUT_EN.
module mode_sequencer
  import mode_seq_pkg::*;
#(
  parameter  int NUM_MODES          = 4,
  parameter  int DEBOUNCE_CYCLES    = 4,
  parameter  int LONG_PRESS_CYCLES  = 16,
  parameter  int IDLE_TIMEOUT_TICKS = 64,
  localparam int MODE_W             = mode_width(NUM_MODES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_en,
  input  logic              btn_adv,
  input  logic              btn_back,
  output logic [MODE_W-1:0] mode,
  output logic              mode_change,
  output logic              btn_held
);

  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

  seq_state_e        r_state, w_state_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic [MODE_W-1:0] r_mode, w_mode_nxt;
  logic              r_change, w_change_nxt;
  logic              r_owner_back, w_owner_nxt;

  logic w_adv_rise, w_adv_fall, w_back_rise, w_back_fall;
  logic w_unused_adv_level, w_unused_back_level;
  logic w_any_rise, w_owner_fall, w_timeout;
  logic [MODE_W-1:0] w_mode_inc, w_mode_dec;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_adv (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_adv),
    .o_level (w_unused_adv_level),
    .o_rise  (w_adv_rise),
    .o_fall  (w_adv_fall)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_back (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_back),
    .o_level (w_unused_back_level),
    .o_rise  (w_back_rise),
    .o_fall  (w_back_fall)
  );

  assign w_any_rise   = w_adv_rise | w_back_rise;
  assign w_owner_fall = r_owner_back ? w_back_fall : w_adv_fall;
  assign w_mode_inc   = (r_mode == LAST_MODE) ? '0 : r_mode + 1'b1;
  assign w_mode_dec   = (r_mode == '0) ? LAST_MODE : r_mode - 1'b1;

`ifdef MODE_SEQ_TIMEOUT_EN
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT_TICKS + 1);
  logic [IDLE_W-1:0] r_idle_cnt;

  // A rise in the same cycle always beats the timeout.
  assign w_timeout = (r_state == ST_IDLE) && (r_mode != '0) && tick_en && !w_any_rise &&
                     (r_idle_cnt == IDLE_W'(IDLE_TIMEOUT_TICKS - 1));

  // Count ticks spent idle away from home; any activity or home mode clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                          r_idle_cnt <= '0;
    else if (r_state != ST_IDLE || r_mode == '0 || w_any_rise || w_timeout) r_idle_cnt <= '0;
    else if (tick_en)                                                 r_idle_cnt <= r_idle_cnt + 1'b1;
  end
`else
  logic w_unused_tick;
  assign w_unused_tick = tick_en;
  assign w_timeout     = 1'b0;
`endif

  // State, hold counter, mode and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_hold       <= '0;
      r_mode       <= '0;
      r_change     <= 1'b0;
      r_owner_back <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold       <= w_hold_nxt;
      r_mode       <= w_mode_nxt;
      r_change     <= w_change_nxt;
      r_owner_back <= w_owner_nxt;
    end
  end

  // Next-state and next-mode decisions for the press FSM.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold;
    w_mode_nxt   = r_mode;
    w_change_nxt = 1'b0;
    w_owner_nxt  = r_owner_back;
    unique case (r_state)
      ST_IDLE: begin
        w_hold_nxt = '0;
        if (w_adv_rise) begin
          w_state_nxt = ST_HELD_ADV;
          w_owner_nxt = 1'b0;
        end else if (w_back_rise) begin
          w_state_nxt = ST_HELD_BACK;
          w_owner_nxt = 1'b1;
        end else if (w_timeout) begin
          w_mode_nxt   = '0;
          w_change_nxt = 1'b1;
        end
      end
      ST_HELD_ADV, ST_HELD_BACK: begin
        if (r_hold == HOLD_LONG) begin
          w_state_nxt  = ST_LOCKED;
          w_mode_nxt   = '0;
          w_change_nxt = (r_mode != '0);
        end else if (w_owner_fall) begin
          w_state_nxt  = ST_IDLE;
          w_mode_nxt   = r_owner_back ? w_mode_dec : w_mode_inc;
          w_change_nxt = 1'b1;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (w_owner_fall) w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign mode        = r_mode;
  assign mode_change = r_change;
  assign btn_held    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mode_sequencer.sv
// Scoreboard bench for mode_sequencer: a 4-mode and a 5-mode instance share
// stimulus; a modulo-arithmetic model queues expected mode values and pulse
// cycles, and per-instance monitors compare on every mode_change pulse.
module tb_mode_sequencer;

  localparam int DEB  = 4;
  localparam int LONG = 16;
  localparam int N4   = 4;
  localparam int N5   = 5;

  typedef struct {
    int mode;
    int cyc;   // expected pulse cycle, or -1 when only the value is checked
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_en = 1'b0;
  logic       btn_adv = 1'b0;
  logic       btn_back = 1'b0;
  logic [1:0] mode4;
  logic [2:0] mode5;
  logic       chg4, chg5, held4, held5;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   m4 = 0;
  int   m5 = 0;
  exp_t q4[$];
  exp_t q5[$];
  exp_t e4, e5;
  logic prev4 = 1'b0;
  logic prev5 = 1'b0;

  mode_sequencer #(.NUM_MODES(N4)) u_dut4 (
    .clk(clk), .rst(rst), .tick_en(tick_en), .btn_adv(btn_adv), .btn_back(btn_back),
    .mode(mode4), .mode_change(chg4), .btn_held(held4)
  );

  mode_sequencer #(.NUM_MODES(N5)) u_dut5 (
    .clk(clk), .rst(rst), .tick_en(tick_en), .btn_adv(btn_adv), .btn_back(btn_back),
    .mode(mode5), .mode_change(chg5), .btn_held(held5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the 4-mode instance.
  always @(negedge clk) begin
    if (rst) prev4 <= 1'b0;
    else begin
      if (chg4) begin
        check("dut4 pulse not back-to-back", int'(prev4), 0);
        check("dut4 pulse was expected", int'(q4.size() > 0), 1);
        if (q4.size() > 0) begin
          e4 = q4.pop_front();
          check("dut4 mode value", int'(mode4), e4.mode);
          if (e4.cyc >= 0) check("dut4 pulse cycle", cyc, e4.cyc);
        end
      end
      prev4 <= chg4;
    end
  end

  // Monitor for the 5-mode instance.
  always @(negedge clk) begin
    if (rst) prev5 <= 1'b0;
    else begin
      if (chg5) begin
        check("dut5 pulse not back-to-back", int'(prev5), 0);
        check("dut5 pulse was expected", int'(q5.size() > 0), 1);
        if (q5.size() > 0) begin
          e5 = q5.pop_front();
          check("dut5 mode value", int'(mode5), e5.mode);
          if (e5.cyc >= 0) check("dut5 pulse cycle", cyc, e5.cyc);
        end
      end
      prev5 <= chg5;
    end
  end

  // Reference model: short press steps the mode modulo N.
  task automatic expect_short(input bit is_back, input int c);
    m4 = is_back ? (m4 + N4 - 1) % N4 : (m4 + 1) % N4;
    m5 = is_back ? (m5 + N5 - 1) % N5 : (m5 + 1) % N5;
    q4.push_back('{m4, c});
    q5.push_back('{m5, c});
  endtask

  // Reference model: return to home, pulsing only if the mode actually changes.
  task automatic expect_home(input int c);
    if (m4 != 0) q4.push_back('{0, c});
    if (m5 != 0) q5.push_back('{0, c});
    m4 = 0;
    m5 = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input bit is_back, input logic v);
    if (is_back) btn_back = v;
    else         btn_adv  = v;
  endtask

  // Release at cycle c: debounced fall at c+2+DEB, mode visible one cycle later.
  task automatic short_press(input bit is_back, input int len);
    @(negedge clk);
    set_btn(is_back, 1'b1);
    step(len);
    set_btn(is_back, 1'b0);
    expect_short(is_back, cyc + 2 + DEB + 1);
    step(12);
  endtask

  task automatic long_press(input bit is_back, input int len);
    @(negedge clk);
    set_btn(is_back, 1'b1);
    expect_home(-1);
    step(2 + DEB + LONG + 8);
    check("dut4 btn_held during long press", int'(held4), 1);
    check("dut5 btn_held during long press", int'(held5), 1);
    step(len - (2 + DEB + LONG + 8));
    set_btn(is_back, 1'b0);
    step(12);
    check("dut4 btn_held after release", int'(held4), 0);
    check("dut5 btn_held after release", int'(held5), 0);
  endtask

  // Both buttons rise together; advance owns the press, back is released later.
  task automatic dual_press(input int len_a, input int extra_b);
    @(negedge clk);
    btn_adv  = 1'b1;
    btn_back = 1'b1;
    step(len_a);
    btn_adv = 1'b0;
    expect_short(1'b0, cyc + 2 + DEB + 1);
    step(extra_b);
    btn_back = 1'b0;
    step(14);
  endtask

  // Chatter (2-cycle runs) followed by a clean high run: one advance only.
  task automatic bouncy_adv();
    logic [9:0] pattern;
    pattern = 10'b11_0011_0011;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      btn_adv = pattern[i];
    end
    step(8);
    btn_adv = 1'b0;
    expect_short(1'b0, cyc + 2 + DEB + 1);
    step(12);
  endtask

  task automatic send_ticks(input int n, input bit home_on_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick_en = 1'b1;
      if (home_on_last && i == n - 1) expect_home(cyc + 1);
      @(negedge clk);
      tick_en = 1'b0;
      step(1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    step(2);
    check("dut4 mode in reset", int'(mode4), 0);
    check("dut5 mode in reset", int'(mode5), 0);
    check("dut4 mode_change in reset", int'(chg4), 0);
    check("dut4 btn_held in reset", int'(held4), 0);
    m4 = 0;
    m5 = 0;
    q4.delete();
    q5.delete();
    rst = 1'b0;
    step(4);
  endtask

  initial begin
    int kind;
    step(3);
    check("dut4 mode after power-up reset", int'(mode4), 0);
    check("dut5 mode after power-up reset", int'(mode5), 0);
    check("dut4 btn_held after power-up reset", int'(held4), 0);
    check("dut5 mode_change after power-up reset", int'(chg5), 0);
    rst = 1'b0;
    step(5);

    // Directed sequence: stepping, wrap in both directions, long presses.
    for (int i = 0; i < 4; i++) short_press(1'b0, 8);
    short_press(1'b1, 8);
    long_press(1'b0, 30);
    short_press(1'b1, 8);
    short_press(1'b0, 8);
    short_press(1'b0, 8);
    short_press(1'b0, 8);
    long_press(1'b0, 30);
    bouncy_adv();
    dual_press(6, 3);
    short_press(1'b1, 7);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1:    short_press(1'b0, $urandom_range(5, 12));
        2:       short_press(1'b1, $urandom_range(5, 12));
        3:       long_press(kind[0], $urandom_range(32, 45));
        4:       dual_press($urandom_range(5, 10), $urandom_range(1, 4));
        default: bouncy_adv();
      endcase
      check("dut4 mode vs model", int'(mode4), m4);
      check("dut5 mode vs model", int'(mode5), m5);
    end

    // Reset in the middle of a press; the still-held button re-rises afterwards.
    short_press(1'b0, 8);
    @(negedge clk);
    btn_adv = 1'b1;
    step(10);
    rst = 1'b1;
    step(2);
    check("dut4 mode after mid-press reset", int'(mode4), 0);
    check("dut4 btn_held after mid-press reset", int'(held4), 0);
    check("dut5 mode after mid-press reset", int'(mode5), 0);
    m4 = 0;
    m5 = 0;
    q4.delete();
    q5.delete();
    rst = 1'b0;
    step(8);
    btn_adv = 1'b0;
    expect_short(1'b0, cyc + 2 + DEB + 1);
    step(12);

    // Idle timeout behaviour from mode 2.
    do_reset();
    short_press(1'b0, 8);
    short_press(1'b0, 8);
`ifdef MODE_SEQ_TIMEOUT_EN
    send_ticks(63, 1'b0);
    check("dut4 mode after 63 ticks", int'(mode4), 2);
    short_press(1'b0, 8);
    send_ticks(64, 1'b1);
    step(4);
    check("dut4 mode after timeout", int'(mode4), 0);
    check("dut5 mode after timeout", int'(mode5), 0);
`else
    send_ticks(200, 1'b0);
    check("dut4 mode after 200 ticks", int'(mode4), 2);
    check("dut5 mode after 200 ticks", int'(mode5), 2);
`endif

    step(40);
    check("dut4 scoreboard drained", q4.size(), 0);
    check("dut5 scoreboard drained", q5.size(), 0);
    check("dut4 final mode", int'(mode4), m4);
    check("dut5 final mode", int'(mode5), m5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
Parametrised successor to the alarm-clock press/release mode FSM. It cycles through NUM_MODES user modes from two debounced buttons:
- advance moves forward with wrap-around.
- back moves backward with wrap-around.
- long press on either button jumps to mode 0 (home).
- optional idle timeout also returns to home.
It sits between raw board buttons and the clock/alarm datapath, which decodes the mode output.

Parameters:
NUM_MODES, 4, number of modes (>=2); mode 0 is home
DEBOUNCE_CYCLES, 4, consecutive equal synchronised samples required to accept a new button level
LONG_PRESS_CYCLES, 16, clk cycles a debounced press must last to count as a long press
IDLE_TIMEOUT_TICKS, 64, tick_en pulses with no press (mode != 0) before auto-return to home

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
tick_en  input  1  slow timebase strobe; advances only the idle-timeout counter
btn_adv  input  1  raw advance button, asynchronous, active-high
btn_back  input  1  raw back button, asynchronous, active-high
mode  output  MODE_W  current mode, MODE_W = max(1, clog2(NUM_MODES))
mode_change  output  1  one-cycle pulse in the cycle mode takes a new value
btn_held  output  1  high while the FSM is in HELD or LOCKED

Behaviour:
- Reset (async): mode=0, mode_change=0, btn_held=0, FSM=IDLE, all counters=0, debouncer outputs=0, synchronisers=0.
- Debounce, per button:
  - 2-FF synchroniser feeds a stability counter.
  - Debounced level flips after DEBOUNCE_CYCLES consecutive samples differing from it.
  - Rise/fall strobes last one cycle.
- FSM states: IDLE, HELD_ADV, HELD_BACK, LOCKED.
- IDLE:
  - adv rise -> HELD_ADV.
  - else back rise -> HELD_BACK.
  - Simultaneous rises: advance wins; back is ignored until it is released and pressed again.
  - Hold counter clears on entry to either HELD state.
- HELD_x:
  - Hold counter increments every clk and saturates.
  - Debounced fall of the owning button before count reaches LONG_PRESS_CYCLES -> IDLE. On that transition the next cycle sets mode to (mode+1) mod NUM_MODES for advance or (mode-1) mod NUM_MODES for back, with mode_change=1.
  - Count reaches LONG_PRESS_CYCLES -> LOCKED. Next cycle sets mode=0; mode_change=1 only if mode was nonzero.
  - The other button is ignored in HELD states.
- LOCKED:
  - Waits for the owning button's debounced fall -> IDLE, with no mode change.
- Wrap-around:
  - Advance from NUM_MODES-1 gives 0.
  - Back from 0 gives NUM_MODES-1.
  - Holds for non-power-of-2 NUM_MODES; mode never exceeds NUM_MODES-1.
- Latency: mode and mode_change update exactly 1 clk after the debounced-fall cycle. Raw edge to debounced edge = 2 + DEBOUNCE_CYCLES clk.
- Reset mid-press: returns to IDLE/mode 0. A button still held after reset is seen as a new rise only after its debounced level rises from 0.
- mode_change is never asserted in two consecutive cycles.

Optional Feature:
MODE_SEQ_TIMEOUT_EN:
- Defined:
  - In IDLE with mode != 0, the idle counter increments on each tick_en.
  - On reaching IDLE_TIMEOUT_TICKS: mode=0, mode_change=1, counter cleared.
  - Counter clears on any debounced rise, on leaving IDLE, and whenever mode==0.
  - A timeout and a rise in the same cycle: the rise wins and no timeout occurs.
- Undefined: no idle counter; tick_en is ignored; mode holds indefinitely.

Decomposition:
- Package mode_seq_pkg: FSM state enum (IDLE, HELD_ADV, HELD_BACK, LOCKED) and a mode_width function (max(1, clog2(n))).
- One sub-module btn_debounce (parameter DEBOUNCE_CYCLES), instantiated twice. Outputs: level, rise, fall.

Test Plan:
- Reset, then 3 short adv presses (hold 8 clk each, DEBOUNCE 4) -> mode 1,2,3, one mode_change per release, each 1 clk after the debounced fall; a 4th press -> mode 0 (wrap).
- From mode 0, short back press -> mode 3. Build with NUM_MODES=5, back from 0 -> mode 4.
- Set mode=2, hold adv 30 clk -> btn_held=1; mode=0 with mode_change at hold count 16+1; no further change on release.
- Bouncing adv input (toggling every 2 clk for 10 clk, then stable high 20 clk, then low) -> exactly one advance.
- Adv and back rise in the same cycle, both short -> only +1 applied; back ignored until re-pressed.
- With MODE_SEQ_TIMEOUT_EN, mode=2, no presses, 64 tick_en -> mode=0 with one mode_change pulse. A press at tick 63 -> no timeout. Without the macro, 200 ticks -> mode stays 2.
